// File: rtl/spi_wb_version_bridge.sv
// SPI mode-0 slave that drives a 32-bit Wishbone master, with a read-only version register.
// Frames: cmd, len[2], addr[4], then data; MISO answers SYNC, cmd&7F, zero pad, then read data.
module spi_wb_version_bridge #(
  parameter logic [31:0] VERSION   = 32'hDEADBEEF,
  parameter logic [7:0]  SYNC_BYTE = 8'hDA
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_RD, S_WR, S_SKIP} state_e;

  localparam logic [7:0] CMD_RD = 8'hA1;
  localparam logic [7:0] CMD_WR = 8'hA2;

  // [0],[1] synchroniser, [2] previous synced value for edge detect
  logic [2:0]  sclk_q, cs_q;
  logic [1:0]  mosi_q;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

  state_e      state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d, cmd_q, cmd_d, rx_byte, tx_next;
  logic        miso_q, miso_d;
  logic [15:0] idx_q, idx_d, len_q, len_d;
  logic [31:0] addr_q, addr_d, wdat_q, wdat_d, rdat_q, rdat_d;
  logic [16:0] n17, k17, len_r, rd_off, rk, wo;

  logic        cyc_q, cyc_d, we_q, we_d, ack_q, ack_d;
  logic [31:8] adr_q, adr_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        start, start_we, slv_hit, slv_err;
  logic [31:0] start_adr;
  logic [3:0]  wb_sel;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign mosi_s    = mosi_q[1];

  assign rx_byte = {rx_q[6:0], mosi_s};
  assign n17     = {1'b0, idx_q};
  assign k17     = n17 + 17'd1;
  assign len_r   = ({1'b0, len_q} + 17'd3) & 17'h1FFFC;
  assign rd_off  = k17 - 17'd8;
  assign rk      = k17 - 17'd7;
  assign wo      = n17 - 17'd7;

  assign wb_sel  = 4'hF;
  assign slv_hit = (adr_q == 24'd0);
  assign slv_err = cyc_q & ~slv_hit;
  assign ack_d   = cyc_q & slv_hit & (|wb_sel) & ~ack_q;

  assign spi_miso = miso_q;
  assign busy     = cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      idx_q   <= '0;
      cmd_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      tmo_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      tmo_q   <= tmo_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q; bit_d = bit_q; rx_d = rx_q; tx_d = tx_q; miso_d = miso_q;
    idx_d = idx_q; cmd_d = cmd_q; len_d = len_q; addr_d = addr_q;
    wdat_d = wdat_q; rdat_d = rdat_q;
    cyc_d = cyc_q; we_d = we_q; adr_d = adr_q; tmo_d = tmo_q;
    start = 1'b0; start_we = 1'b0; start_adr = addr_q; tx_next = '0;

    if (cs_rise) begin
      state_d = S_IDLE; bit_d = '0; rx_d = '0; tx_d = '0; miso_d = 1'b0;
    end else if (cs_fall) begin
      state_d = S_HDR; bit_d = '0; rx_d = '0; idx_d = '0;
      tx_d = {SYNC_BYTE[6:0], 1'b0}; miso_d = SYNC_BYTE[7];
      cmd_d = '0; len_d = '0; addr_d = '0; wdat_d = '0;
    end else if (state_q != S_IDLE) begin
      if (sclk_fall) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
      if (sclk_rise) begin
        rx_d  = rx_byte;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          idx_d = (&idx_q) ? idx_q : idx_q + 16'd1;
          if (idx_q == 16'd0)
            tx_next = rx_byte & 8'h7F;
          else if (state_q == S_RD && k17 >= 17'd8 && rd_off < len_r)
            tx_next = rdat_q[{rd_off[1:0], 3'b000} +: 8];
          tx_d = tx_next;
          case (state_q)
            S_HDR: begin
              case (idx_q)
                16'd0: begin
                  cmd_d = rx_byte;
                  if (rx_byte != CMD_RD && rx_byte != CMD_WR) state_d = S_SKIP;
                end
                16'd1: len_d[7:0]    = rx_byte;
                16'd2: len_d[15:8]   = rx_byte;
                16'd3: addr_d[7:0]   = rx_byte;
                16'd4: addr_d[15:8]  = rx_byte;
                16'd5: addr_d[23:16] = rx_byte;
                16'd6: begin
                  addr_d  = {rx_byte, addr_q[23:0]};
                  state_d = (cmd_q == CMD_RD) ? S_RD : S_WR;
                  // First read word is fetched while pad byte 7 shifts out
                  if (cmd_q == CMD_RD && len_r != 17'd0) begin
                    start     = 1'b1;
                    start_adr = {rx_byte, addr_q[23:0]};
                    addr_d    = start_adr + 32'd4;
                  end
                end
                default: ;
              endcase
            end
            S_RD: begin
              // Prefetch the next word as the current word's last byte is loaded
              if (rk[1:0] == 2'd0 && rk < len_r) begin
                start  = 1'b1;
                addr_d = addr_q + 32'd4;
              end
            end
            S_WR: begin
              wdat_d = {rx_byte, wdat_q[31:8]};
              if (wo[1:0] == 2'd3 && (wo + 17'd1) <= {1'b0, len_q}) begin
                start    = 1'b1;
                start_we = 1'b1;
                addr_d   = addr_q + 32'd4;
              end
            end
            default: ;
          endcase
        end
      end
    end

    // Wishbone master runs independently of the frame so a CS rise cannot cut a cycle short
    if (cyc_q) begin
      if (ack_q) begin
        cyc_d = 1'b0;
        if (!we_q) rdat_d = VERSION;
      end else if (slv_err || tmo_q == 8'd254) begin
        cyc_d = 1'b0;
        if (!we_q) rdat_d = 32'hEEEEEEEE;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end else if (start) begin
      cyc_d = 1'b1;
      we_d  = start_we;
      adr_d = start_adr[31:8];
      tmo_d = '0;
    end
  end

endmodule

// File: tb/tb_spi_wb_version_bridge.sv
// Randomised frame-level bench: a byte/transaction model fills expectation queues, monitors drain them.
module tb_spi_wb_version_bridge;

  localparam logic [31:0] VERSION = 32'hDEADBEEF;
  localparam logic [7:0]  SYNC    = 8'hDA;

  logic clk = 1'b0;
  logic rst, spi_sclk, spi_cs_n, spi_mosi;
  logic spi_miso, busy;

  always #5 clk = ~clk;

  spi_wb_version_bridge #(.VERSION(VERSION), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy)
  );

  typedef struct packed {
    logic        we;
    logic [23:0] adr_hi;
    logic [31:0] dat;
  } wb_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  wb_t         wb_q[$];
  logic [7:0]  fb[0:63];
  bit          mon_en = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wordat(input logic [31:0] a);
    return (a[31:8] == 24'd0) ? VERSION : 32'hEEEEEEEE;
  endfunction

  // Expected MISO bytes and bus transactions for a frame of nb host bytes in fb[]
  task automatic model(input int nb);
    logic [7:0]  cmd, e;
    logic [31:0] len, lr, addr, w;
    cmd  = fb[0];
    len  = (nb > 2) ? {16'd0, fb[2], fb[1]} : 32'd0;
    addr = (nb > 6) ? {fb[6], fb[5], fb[4], fb[3]} : 32'd0;
    lr   = (len + 32'd3) / 32'd4 * 32'd4;
    for (int k = 0; k < nb; k++) begin
      if (k == 0) e = SYNC;
      else if (k == 1) e = cmd & 8'h7F;
      else if (k < 8) e = 8'h00;
      else if (cmd == 8'hA1 && 32'(k - 8) < lr) begin
        w = wordat(addr + 32'((k - 8) / 4 * 4));
        e = w[8 * ((k - 8) % 4) +: 8];
      end else e = 8'h00;
      exp_q.push_back(e);
    end
    if (cmd == 8'hA1 && nb >= 7)
      for (int i = 0; 32'(4 * i) < lr; i++)
        if (nb >= 7 + 4 * i) wb_q.push_back('{1'b0, 24'(((addr + 32'(4 * i)) >> 8)), 32'd0});
    if (cmd == 8'hA2 && nb >= 7)
      for (int i = 0; 32'(4 * i + 4) <= len; i++)
        if (nb >= 11 + 4 * i)
          wb_q.push_back('{1'b1, 24'(((addr + 32'(4 * i)) >> 8)),
                           {fb[10 + 4 * i], fb[9 + 4 * i], fb[8 + 4 * i], fb[7 + 4 * i]}});
  endtask

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic shift_bytes(input int nb);
    for (int i = 0; i < nb; i++)
      for (int b = 7; b >= 0; b--) begin
        spi_mosi = fb[i][b];
        half();
        spi_sclk = 1'b1;
        half();
        spi_sclk = 1'b0;
      end
  endtask

  task automatic frame(input int nb);
    model(nb);
    spi_cs_n = 1'b0;
    half();
    shift_bytes(nb);
    half();
    spi_cs_n = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic set_hdr(input logic [7:0] cmd, input logic [15:0] len, input logic [31:0] addr);
    fb[0] = cmd; fb[1] = len[7:0]; fb[2] = len[15:8];
    fb[3] = addr[7:0]; fb[4] = addr[15:8]; fb[5] = addr[23:16]; fb[6] = addr[31:24];
  endtask

  task automatic std_read();
    set_hdr(8'hA1, 16'd4, 32'd0);
    for (int i = 7; i < 11; i++) fb[i] = 8'h55;
    fb[11] = 8'hDA;
    frame(12);
  endtask

  // MISO byte monitor: samples on the host's SCLK rise
  int         bcnt = 0;
  logic [7:0] bsh = '0;
  always @(posedge spi_sclk or posedge spi_cs_n) begin
    if (spi_cs_n) bcnt = 0;
    else if (mon_en) begin
      bsh = {bsh[6:0], spi_miso};
      bcnt++;
      if (bcnt == 8) begin
        bcnt = 0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL miso_extra: got %h expected no byte", bsh);
        end else chk("miso_byte", 64'(bsh), 64'(exp_q.pop_front()));
      end
    end
  end

  // Bus monitor: one expectation per rising busy
  logic pbusy = 1'b0;
  always @(negedge clk) begin
    wb_t e;
    if (busy && !pbusy) begin
      if (wb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_extra: got we=%0d adr_hi=%h expected no cycle", dut.we_q, dut.adr_q);
      end else begin
        e = wb_q.pop_front();
        chk("wb_we", 64'(dut.we_q), 64'(e.we));
        chk("wb_adr", 64'(dut.adr_q), 64'(e.adr_hi));
        if (e.we) chk("wb_dat", 64'(dut.wdat_q), 64'(e.dat));
      end
    end
    pbusy = busy;
  end

  initial begin
    logic [31:0] r;
    int nb;
    rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", 64'(spi_miso), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    std_read();
    for (int i = 0; i < 25; i++) std_read();

    set_hdr(8'hA1, 16'd8, 32'd0);
    for (int i = 7; i < 16; i++) fb[i] = 8'h00;
    frame(16);

    set_hdr(8'hA1, 16'd4, 32'h0000_0100);
    frame(12);
    std_read();

    set_hdr(8'hA2, 16'd4, 32'd0);
    fb[7] = 8'h11; fb[8] = 8'h22; fb[9] = 8'h33; fb[10] = 8'h44;
    frame(11);
    std_read();

    set_hdr(8'hA1, 16'd4, 32'd0);
    frame(5);
    std_read();

    // Reset in the middle of a frame, with CS still low across the release
    mon_en = 1'b0;
    set_hdr(8'hA1, 16'd4, 32'd0);
    spi_cs_n = 1'b0;
    half();
    shift_bytes(2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_miso", 64'(spi_miso), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("postrst_miso", 64'(spi_miso), 64'd0);
    spi_cs_n = 1'b1;
    repeat (30) @(negedge clk);
    mon_en = 1'b1;
    std_read();

    for (int f = 0; f < 20; f++) begin
      nb = ($urandom_range(0, 3) != 0) ? 7 + int'($urandom_range(0, 12)) : int'($urandom_range(1, 6));
      case ($urandom_range(0, 3))
        0, 1: fb[0] = 8'hA1;
        2:    fb[0] = 8'hA2;
        default: fb[0] = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: r = 32'd0;
        1: r = {24'd0, 8'($urandom)};
        2: r = 32'h0000_0100;
        default: r = $urandom;
      endcase
      set_hdr(fb[0], 16'($urandom_range(0, 12)), r);
      for (int i = 7; i < 20; i++) fb[i] = 8'($urandom);
      frame(nb);
    end

    repeat (50) @(negedge clk);
    chk("miso_pending", 64'(exp_q.size()), 64'd0);
    chk("wb_pending", 64'(wb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
